// File: rtl/instruction_fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: reset/NOP defaults,
// FSM state encoding and the sequential-PC helper.
package instruction_fetch_stage_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_NOP_WORD = 32'd0;
  localparam logic [31:0] PC_STEP          = 32'd4;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_t;

  // Modulo-2^32 add; the low two bits pass through untouched.
  function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/pc_register.sv
// Program counter: 32-bit async-reset register with a load port and a
// +4 sequential increment path. Load has priority over increment.
module pc_register
  import instruction_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_en,
  input  logic [31:0] load_value,
  input  logic        inc_en,
  output logic [31:0] pc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (load_en) begin
      pc <= load_value;
    end else if (inc_en) begin
      pc <= next_seq_pc(pc);
    end
  end

endmodule

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: requests words from instruction memory, buffers one
// for the IF/ID register, parks one more in a skid register, handles redirects.
module instruction_fetch_stage
  import instruction_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_WORD = DEFAULT_NOP_WORD
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Fetch_Enable,
  input  logic        Branch_Taken,
  input  logic [31:0] Branch_Target,
  output logic        IMem_Req,
  output logic [31:0] IMem_Addr,
  input  logic        IMem_Ready,
  input  logic [31:0] IMem_Data,
  output logic [31:0] Instruction_IF,
  output logic [31:0] PC_Plus_4_IF
);

  fetch_state_t state, state_next;

  logic [31:0] pc;
  logic        pc_load;
  logic        pc_inc;
  logic [31:0] pc_load_value;

  logic [31:0] inst_buf, inst_buf_next;
  logic [31:0] buf_pc, buf_pc_next;
  logic        buf_valid, buf_valid_next;
  logic [31:0] skid_inst, skid_inst_next;
  logic        discard, discard_next;
  logic [31:0] redirect_pc, redirect_pc_next;

  pc_register #(
    .RESET_PC(RESET_PC)
  ) u_pc_register (
    .clk       (Clk),
    .rst       (Reset),
    .load_en   (pc_load),
    .load_value(pc_load_value),
    .inc_en    (pc_inc),
    .pc        (pc)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= FETCH;
    end else begin
      state <= state_next;
    end
  end

  // A redirect outranks everything; an in-flight access cannot be cancelled,
  // so its response is swallowed later via the discard latch.
  always_comb begin
    state_next       = state;
    inst_buf_next    = inst_buf;
    buf_pc_next      = buf_pc;
    buf_valid_next   = buf_valid;
    skid_inst_next   = skid_inst;
    discard_next     = discard;
    redirect_pc_next = redirect_pc;
    pc_load          = 1'b0;
    pc_inc           = 1'b0;
    pc_load_value    = Branch_Target;

    if (Branch_Taken) begin
      buf_valid_next = 1'b0;
      if (state == HOLD) begin
        pc_load    = 1'b1;
        state_next = FETCH;
      end else if (IMem_Ready) begin
        pc_load      = 1'b1;
        discard_next = 1'b0;
      end else begin
        discard_next     = 1'b1;
        redirect_pc_next = Branch_Target;
      end
    end else if (state == FETCH) begin
      if (Fetch_Enable) begin
        buf_valid_next = 1'b0;
      end
      if (IMem_Ready) begin
        if (discard) begin
          pc_load       = 1'b1;
          pc_load_value = redirect_pc;
          discard_next  = 1'b0;
        end else if (!buf_valid || Fetch_Enable) begin
          inst_buf_next  = IMem_Data;
          buf_pc_next    = pc;
          buf_valid_next = 1'b1;
          pc_inc         = 1'b1;
        end else begin
          // Buffer is stalled: park the word and stop requesting.
          skid_inst_next = IMem_Data;
          state_next     = HOLD;
        end
      end
    end else if (Fetch_Enable) begin
      // PC still names the parked word, so it becomes the buffered address.
      inst_buf_next = skid_inst;
      buf_pc_next   = pc;
      pc_inc        = 1'b1;
      state_next    = FETCH;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      inst_buf    <= '0;
      buf_pc      <= '0;
      buf_valid   <= 1'b0;
      skid_inst   <= '0;
      discard     <= 1'b0;
      redirect_pc <= '0;
    end else begin
      inst_buf    <= inst_buf_next;
      buf_pc      <= buf_pc_next;
      buf_valid   <= buf_valid_next;
      skid_inst   <= skid_inst_next;
      discard     <= discard_next;
      redirect_pc <= redirect_pc_next;
    end
  end

  assign IMem_Req       = (state == FETCH);
  assign IMem_Addr      = pc;
  assign Instruction_IF = buf_valid ? inst_buf : NOP_WORD;
  assign PC_Plus_4_IF   = buf_valid ? next_seq_pc(buf_pc) : '0;

endmodule

// File: doc/instruction_fetch_stage.md
INSTRUCTION_FETCH_STAGE -- requirements
Module: instruction_fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter NOP_WORD, default 32'd0: instruction presented when no valid fetch is buffered.
REQ-003 Clk  input  1  single clock; all state updates on its positive edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 Fetch_Enable  input  1  downstream accept; the IF/ID register's enable, so 1 = buffered instruction consumed this edge.
REQ-006 Branch_Taken  input  1  redirect request from ID, single-cycle pulse.
REQ-007 Branch_Target  input  32  redirect PC, valid when Branch_Taken=1.
REQ-008 IMem_Req  output  1  instruction memory request.
REQ-009 IMem_Addr  output  32  word address of the request, the current PC.
REQ-010 IMem_Ready  input  1  memory has returned IMem_Data this cycle; latency 0..N cycles.
REQ-011 IMem_Data  input  32  returned instruction word.
REQ-012 Instruction_IF  output  32  buffered instruction, or NOP_WORD when the buffer is empty.
REQ-013 PC_Plus_4_IF  output  32  address of the buffered instruction + 4, or 0 when the buffer is empty.

Function
REQ-014 Two states: FETCH (IMem_Req=1) and HOLD (IMem_Req=0).
REQ-015 Output buffer: inst_buf, buf_pc, buf_valid; skid register: skid_inst; redirect latch: discard, redirect_pc.
REQ-016 IMem_Addr = PC and holds stable while IMem_Req=1 until IMem_Ready=1.
REQ-017 FETCH, IMem_Ready=1, discard=0, buffer free (buf_valid=0 or Fetch_Enable=1): inst_buf<=IMem_Data, buf_pc<=PC, buf_valid<=1, PC<=PC+4, stay FETCH.
REQ-018 FETCH, IMem_Ready=1, discard=0, buffer full and Fetch_Enable=0: skid_inst<=IMem_Data, go HOLD, PC unchanged.
REQ-019 HOLD, Fetch_Enable=1: inst_buf<=skid_inst, buf_pc<=PC, PC<=PC+4, go FETCH.
REQ-020 Buffer consumed with no new word (Fetch_Enable=1, no fill this edge): buf_valid<=0.
REQ-021 Branch_Taken=1 has priority over every other event; no delay slot; buf_valid<=0 and the skid word is dropped.
REQ-022 Branch during FETCH with IMem_Ready=1: returned word dropped, PC<=Branch_Target.
REQ-023 Branch during FETCH with IMem_Ready=0: discard<=1, redirect_pc<=Branch_Target; PC and IMem_Addr are unchanged.
REQ-024 Branch during HOLD: PC<=Branch_Target, go FETCH.
REQ-025 FETCH, IMem_Ready=1, discard=1: word dropped, PC<=redirect_pc, discard<=0.
REQ-026 A second Branch_Taken while discard=1 overwrites redirect_pc; the last redirect wins.
REQ-027 PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0; bits [1:0] are never altered.

Reset
REQ-028 On Reset assertion, immediately and independent of Clk: PC=RESET_PC, state=FETCH, buf_valid=0, discard=0, inst_buf=skid_inst=buf_pc=redirect_pc=0.
REQ-029 During reset, outputs are Instruction_IF=NOP_WORD, PC_Plus_4_IF=0, IMem_Req=1, IMem_Addr=RESET_PC.
REQ-030 Reset mid-request abandons the outstanding access; an IMem_Ready in the first cycle after release is taken as the response for RESET_PC.

Structure
REQ-031 Shared package holds the RESET_PC default, the NOP_WORD encoding and the FETCH/HOLD state encoding.
REQ-032 There is one sub-module, pc_register: a 32-bit async-reset register with load enable and the +4 incrementer.

Verification
REQ-033 Reset release, IMem_Ready tied 1, Fetch_Enable=1 -> IMem_Addr 0,4,8; PC_Plus_4_IF 4,8,12 one cycle later.
REQ-034 Fetch_Enable=0 for 3 cycles with one word buffered and one returned -> HOLD entered, IMem_Req=0, Instruction_IF stable; re-enable -> skid word presented next cycle, no word lost or duplicated.
REQ-035 Branch_Taken to 32'h100 while a 3-cycle-latency fetch to 0x8 is outstanding -> IMem_Addr stays 0x8 until ready; that word is dropped; next IMem_Addr=0x100.
REQ-036 Branch_Taken and Fetch_Enable=0 in the same cycle in HOLD -> Instruction_IF=NOP_WORD next cycle; IMem_Addr=target.
REQ-037 Reset asserted mid-wait at PC=0x40 -> outputs go to reset values before the next Clk edge; IMem_Addr=0 after release.
REQ-038 PC preset near 32'hFFFF_FFFC via branch, continuous fetch -> IMem_Addr wraps to 0; PC_Plus_4_IF=0 for the word at 32'hFFFF_FFFC.
